// File: rtl/dbg_ctrl_if.sv
// CSR access bus between the core CSR file and the debug control stage.
// The core drives the write strobe, address and data; the debug stage returns read data.
interface dbg_ctrl_if;
    logic        csr_wr_en;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (output csr_wr_en, csr_idx, csr_wdata, input csr_rdata);
    modport slave  (input csr_wr_en, csr_idx, csr_wdata, output csr_rdata);
endinterface

// File: rtl/dbg_ctrl.sv
// Debug-mode control: RUN/DEBUG/RESUME state, dcsr/dpc/dscratch, and the pending
// irq/halt/step requests that feed the debug-entry arbiter.
module dbg_ctrl #(
    parameter int         PC_W   = 32,
    parameter logic [3:0] DBGVER = 4'd4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dbg_haltreq_i,
    input  logic            dbg_irq_i,
    input  logic            dbg_entry_taken_ena,
    input  logic [2:0]      dbg_entry_cause,
    input  logic [PC_W-1:0] dbg_entry_pc,
    input  logic            cmt_dret_ena,
    dbg_ctrl_if.slave       csr,
    output logic            dbg_irq_r,
    output logic            dbg_halt_r,
    output logic            dbg_step_r,
    output logic            dbg_mode,
    output logic            dbg_ebreakm,
    output logic            dbg_stopcycle,
    output logic            dbg_stoptime,
    output logic            dbg_halted,
    output logic            dbg_resumeack,
    output logic [PC_W-1:0] dpc_r
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DEBUG  = 2'b01;
    localparam logic [1:0] ST_RESUME = 2'b10;

    localparam logic [11:0] CSR_DCSR     = 12'h7B0;
    localparam logic [11:0] CSR_DPC      = 12'h7B1;
    localparam logic [11:0] CSR_DSCRATCH = 12'h7B2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_ebreakm;
    logic            r_stopcount;
    logic            r_stoptime;
    logic            r_step;
    logic [2:0]      r_cause;
    logic [31:0]     r_dscratch;

    logic            w_entry;
    logic            w_mode_nxt;
    logic            w_csr_we;
    logic            w_wr_dcsr;
    logic            w_wr_dpc;
    logic            w_wr_dscratch;
    logic [PC_W-1:0] w_entry_pc;
    logic [PC_W-1:0] w_wr_pc;

    // Entry is only honoured from RUN; an entry strobe during RESUME is dropped.
    assign w_entry       = dbg_entry_taken_ena & (r_state == ST_RUN);
    assign w_csr_we      = csr.csr_wr_en & dbg_mode;
    assign w_wr_dcsr     = w_csr_we & (csr.csr_idx == CSR_DCSR);
    assign w_wr_dpc      = w_csr_we & (csr.csr_idx == CSR_DPC);
    assign w_wr_dscratch = w_csr_we & (csr.csr_idx == CSR_DSCRATCH);
    assign w_entry_pc    = dbg_entry_pc & ~PC_W'(1);
    assign w_wr_pc       = PC_W'(csr.csr_wdata) & ~PC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_entry) w_state_nxt = ST_DEBUG;
            ST_DEBUG:  if (cmt_dret_ena) w_state_nxt = ST_RESUME;
            ST_RESUME: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    assign w_mode_nxt = (w_state_nxt == ST_DEBUG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            dbg_halt_r  <= 1'b0;
            dbg_irq_r   <= 1'b0;
            dbg_step_r  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            dbg_halt_r <= dbg_haltreq_i & ~w_mode_nxt & ~dbg_entry_taken_ena;
            dbg_step_r <= r_step & ~w_mode_nxt;
            if (dbg_entry_taken_ena)
                dbg_irq_r <= 1'b0;
            else if (dbg_irq_i && r_state != ST_DEBUG)
                dbg_irq_r <= 1'b1;
        end
    end

    // Entry capture has priority over a same-cycle CSR write to dcsr/dpc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ebreakm   <= 1'b0;
            r_stopcount <= 1'b0;
            r_stoptime  <= 1'b0;
            r_step      <= 1'b0;
            r_cause     <= 3'd0;
            dpc_r       <= '0;
            r_dscratch  <= 32'd0;
        end else begin
            if (w_entry) begin
                r_cause <= dbg_entry_cause;
                dpc_r   <= w_entry_pc;
            end else begin
                if (w_wr_dcsr) begin
                    r_ebreakm   <= csr.csr_wdata[15];
                    r_stopcount <= csr.csr_wdata[10];
                    r_stoptime  <= csr.csr_wdata[9];
                    r_step      <= csr.csr_wdata[2];
                end
                if (w_wr_dpc)
                    dpc_r <= w_wr_pc;
            end
            if (w_wr_dscratch)
                r_dscratch <= csr.csr_wdata;
        end
    end

    always_comb begin
        csr.csr_rdata = 32'd0;
        case (csr.csr_idx)
            CSR_DCSR:     csr.csr_rdata = {DBGVER, 12'd0, r_ebreakm, 4'd0, r_stopcount,
                                           r_stoptime, r_cause, 3'd0, r_step, 2'b11};
            CSR_DPC:      csr.csr_rdata = 32'(dpc_r);
            CSR_DSCRATCH: csr.csr_rdata = r_dscratch;
            default:      csr.csr_rdata = 32'd0;
        endcase
    end

    assign dbg_mode      = (r_state == ST_DEBUG);
    assign dbg_halted    = dbg_mode;
    assign dbg_resumeack = (r_state == ST_RESUME);
    assign dbg_ebreakm   = r_ebreakm;
    assign dbg_stopcycle = r_stopcount & dbg_mode;
    assign dbg_stoptime  = r_stoptime & dbg_mode;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed test of dbg_ctrl: entry/dret sequencing, CSR access rules, pending
// request tracking and asynchronous reset.
module tb_dbg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        dbg_haltreq_i;
    logic        dbg_irq_i;
    logic        dbg_entry_taken_ena;
    logic [2:0]  dbg_entry_cause;
    logic [31:0] dbg_entry_pc;
    logic        cmt_dret_ena;
    logic        dbg_irq_r, dbg_halt_r, dbg_step_r, dbg_mode, dbg_ebreakm;
    logic        dbg_stopcycle, dbg_stoptime, dbg_halted, dbg_resumeack;
    logic [31:0] dpc_r;

    int n_chk = 0;
    int n_err = 0;

    dbg_ctrl_if u_if();

    dbg_ctrl #(.PC_W(32), .DBGVER(4'd4)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dbg_haltreq_i       (dbg_haltreq_i),
        .dbg_irq_i           (dbg_irq_i),
        .dbg_entry_taken_ena (dbg_entry_taken_ena),
        .dbg_entry_cause     (dbg_entry_cause),
        .dbg_entry_pc        (dbg_entry_pc),
        .cmt_dret_ena        (cmt_dret_ena),
        .csr                 (u_if),
        .dbg_irq_r           (dbg_irq_r),
        .dbg_halt_r          (dbg_halt_r),
        .dbg_step_r          (dbg_step_r),
        .dbg_mode            (dbg_mode),
        .dbg_ebreakm         (dbg_ebreakm),
        .dbg_stopcycle       (dbg_stopcycle),
        .dbg_stoptime        (dbg_stoptime),
        .dbg_halted          (dbg_halted),
        .dbg_resumeack       (dbg_resumeack),
        .dpc_r               (dpc_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] idx, output logic [31:0] data);
        u_if.csr_idx = idx;
        #1;
        data = u_if.csr_rdata;
    endtask

    task automatic set_wr(input logic [11:0] idx, input logic [31:0] data);
        u_if.csr_wr_en = 1'b1;
        u_if.csr_idx   = idx;
        u_if.csr_wdata = data;
    endtask

    task automatic clr_in();
        u_if.csr_wr_en      = 1'b0;
        dbg_entry_taken_ena = 1'b0;
        cmt_dret_ena        = 1'b0;
        dbg_irq_i           = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        rst_n = 1'b0;
        dbg_haltreq_i = 1'b0;
        dbg_entry_cause = 3'd0;
        dbg_entry_pc = 32'd0;
        u_if.csr_idx = 12'h000;
        u_if.csr_wdata = 32'd0;
        clr_in();
        tick();
        tick();
        chk("rst_mode", {31'd0, dbg_mode}, 32'd0);
        chk("rst_outs", {23'd0, dbg_irq_r, dbg_halt_r, dbg_step_r, dbg_ebreakm, dbg_stopcycle,
                         dbg_stoptime, dbg_halted, dbg_resumeack, dbg_mode}, 32'd0);
        chk("rst_dpc", dpc_r, 32'd0);
        rd(12'h7B0, v);
        chk("rst_dcsr", v, 32'h4000_0003);
        rd(12'h7B2, v);
        chk("rst_dscratch", v, 32'd0);
        rst_n = 1'b1;
        tick();

        // halt request drops the cycle after it is deasserted
        dbg_haltreq_i = 1'b1;
        tick();
        chk("halt_set", {31'd0, dbg_halt_r}, 32'd1);
        dbg_haltreq_i = 1'b0;
        tick();
        chk("halt_drop", {31'd0, dbg_halt_r}, 32'd0);

        dbg_haltreq_i = 1'b1;
        tick();
        chk("halt_set2", {31'd0, dbg_halt_r}, 32'd1);
        dbg_entry_taken_ena = 1'b1;
        dbg_entry_cause = 3'd5;
        dbg_entry_pc = 32'h8000_0104;
        tick();
        clr_in();
        chk("entry_mode", {31'd0, dbg_mode}, 32'd1);
        chk("entry_halted", {31'd0, dbg_halted}, 32'd1);
        chk("entry_halt_r", {31'd0, dbg_halt_r}, 32'd0);
        chk("entry_dpc", dpc_r, 32'h8000_0104);
        rd(12'h7B0, v);
        chk("entry_cause", {29'd0, v[8:6]}, 32'd5);
        dbg_haltreq_i = 1'b0;

        // CSR writes while in debug mode
        set_wr(12'h7B1, 32'h0000_1235);
        tick();
        clr_in();
        chk("dbg_dpc_wr", dpc_r, 32'h0000_1234);
        set_wr(12'h7B2, 32'hDEAD_BEEF);
        tick();
        clr_in();
        rd(12'h7B2, v);
        chk("dbg_dscratch", v, 32'hDEAD_BEEF);
        set_wr(12'h7B0, 32'h0000_8004);
        tick();
        clr_in();
        chk("dbg_ebreakm", {31'd0, dbg_ebreakm}, 32'd1);
        chk("dbg_step_in_dbg", {31'd0, dbg_step_r}, 32'd0);
        rd(12'h7B0, v);
        chk("dbg_dcsr_rd", v, 32'h4000_8147);

        cmt_dret_ena = 1'b1;
        tick();
        clr_in();
        chk("ret_ack", {31'd0, dbg_resumeack}, 32'd1);
        chk("ret_mode", {31'd0, dbg_mode}, 32'd0);
        tick();
        chk("ret_ack_drop", {31'd0, dbg_resumeack}, 32'd0);
        chk("ret_step", {31'd0, dbg_step_r}, 32'd1);

        // CSR writes dropped in RUN
        set_wr(12'h7B1, 32'h0000_0040);
        tick();
        clr_in();
        chk("run_dpc_wr", dpc_r, 32'h0000_1234);
        set_wr(12'h7B0, 32'd0);
        tick();
        clr_in();
        chk("run_dcsr_wr", {31'd0, dbg_ebreakm}, 32'd1);

        // irq held until entry; entry plus dcsr write in the same cycle
        dbg_irq_i = 1'b1;
        tick();
        clr_in();
        chk("irq_set", {31'd0, dbg_irq_r}, 32'd1);
        tick();
        chk("irq_hold", {31'd0, dbg_irq_r}, 32'd1);
        dbg_entry_taken_ena = 1'b1;
        dbg_entry_cause = 3'd3;
        dbg_entry_pc = 32'h0000_0A01;
        set_wr(12'h7B0, 32'd0);
        tick();
        clr_in();
        chk("irq_clr", {31'd0, dbg_irq_r}, 32'd0);
        chk("entry2_dpc", dpc_r, 32'h0000_0A00);
        chk("entry2_ebreakm", {31'd0, dbg_ebreakm}, 32'd1);
        chk("entry2_step_r", {31'd0, dbg_step_r}, 32'd0);
        rd(12'h7B0, v);
        chk("entry2_cause", {29'd0, v[8:6]}, 32'd3);
        chk("entry2_ver_prv", {26'd0, v[31:28], v[1:0]}, 32'h13);

        dbg_irq_i = 1'b1;
        tick();
        clr_in();
        chk("irq_in_dbg", {31'd0, dbg_irq_r}, 32'd0);

        set_wr(12'h7B0, 32'h0000_0600);
        tick();
        clr_in();
        chk("stop_bits", {30'd0, dbg_stopcycle, dbg_stoptime}, 32'd3);
        rd(12'h7B0, v);
        chk("dcsr_rd2", v, 32'h4000_06C3);

        // dret together with a dscratch write; then an entry during RESUME
        cmt_dret_ena = 1'b1;
        set_wr(12'h7B2, 32'h1234_5678);
        tick();
        clr_in();
        chk("ret2_ack", {31'd0, dbg_resumeack}, 32'd1);
        chk("ret2_stop", {30'd0, dbg_stopcycle, dbg_stoptime}, 32'd0);
        rd(12'h7B2, v);
        chk("ret2_dscratch", v, 32'h1234_5678);
        dbg_entry_taken_ena = 1'b1;
        dbg_entry_cause = 3'd1;
        dbg_entry_pc = 32'h0000_0004;
        tick();
        clr_in();
        chk("resume_entry_mode", {31'd0, dbg_mode}, 32'd0);
        chk("resume_entry_dpc", dpc_r, 32'h0000_0A00);

        // async reset while in debug mode
        dbg_entry_taken_ena = 1'b1;
        dbg_entry_cause = 3'd2;
        dbg_entry_pc = 32'h0000_0100;
        tick();
        clr_in();
        chk("entry3_mode", {31'd0, dbg_mode}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {23'd0, dbg_irq_r, dbg_halt_r, dbg_step_r, dbg_ebreakm, dbg_stopcycle,
                          dbg_stoptime, dbg_halted, dbg_resumeack, dbg_mode}, 32'd0);
        chk("arst_dpc", dpc_r, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_mode", {30'd0, dbg_mode, dbg_resumeack}, 32'd0);
        rd(12'h7B0, v);
        chk("post_rst_dcsr", v, 32'h4000_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
